// File: rtl/gcc_track.sv
// Centroid tracker behind GCC: forms (X, Y, dX, dY, FIRST) records and queues them in a FWFT FIFO.
// Define GCC_TRACK_BBOX_EN to add a running bounding box (XMIN/XMAX/YMIN/YMAX) of the current track.
module gcc_track #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          CLK,
    input  logic          RESET_,
    input  logic          IN_VALID,
    input  logic [DW-1:0] XC_IN,
    input  logic [DW-1:0] YC_IN,
    input  logic          CLR,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] X_OUT,
    output logic [DW-1:0] Y_OUT,
    output logic [DW:0]   DX,
    output logic [DW:0]   DY,
    output logic          FIRST,
    output logic [AW:0]   COUNT,
    output logic          OVERFLOW
`ifdef GCC_TRACK_BBOX_EN
    ,
    output logic [DW-1:0] XMIN,
    output logic [DW-1:0] XMAX,
    output logic [DW-1:0] YMIN,
    output logic [DW-1:0] YMAX
`endif
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    state_t state, state_n;
    logic   first_c;

    logic [DW-1:0] prev_x, prev_y;
    logic [DW:0]   dx_c, dy_c;

    logic [DW-1:0] mem_x  [DEPTH];
    logic [DW-1:0] mem_y  [DEPTH];
    logic [DW:0]   mem_dx [DEPTH];
    logic [DW:0]   mem_dy [DEPTH];
    logic [DEPTH-1:0] mem_first;

    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] count_n;
    logic          push_c, pop_c;

    logic          hv_n, hf_n;
    logic [DW-1:0] hx_n, hy_n;
    logic [DW:0]   hdx_n, hdy_n;

    // Track state register
    always_ff @(posedge CLK) begin
        if (!RESET_) state <= IDLE;
        else         state <= state_n;
    end

    // Track next state; a sample starts a new track in IDLE or alongside CLR
    always_comb begin
        state_n = state;
        first_c = (state == IDLE) || CLR;
        case (state)
            IDLE:    if (IN_VALID) state_n = TRACK;
            TRACK:   if (IN_VALID) state_n = TRACK;
                     else if (CLR) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Deltas are zero-extended differences; a track start reports no motion
    always_comb begin
        dx_c = '0;
        dy_c = '0;
        if (!first_c) begin
            dx_c = {1'b0, XC_IN} - {1'b0, prev_x};
            dy_c = {1'b0, YC_IN} - {1'b0, prev_y};
        end
    end

    assign pop_c   = OUT_VALID && OUT_READY;
    assign push_c  = IN_VALID && ((COUNT != FULL_CNT) || pop_c);
    assign count_n = COUNT + CW'(push_c) - CW'(pop_c);
    assign rd_ptr_n = pop_c ? rd_ptr + AW'(1) : rd_ptr;

    // Next head: the incoming record when nothing older survives the pop, else stored data
    always_comb begin
        hv_n  = 1'b0;
        hx_n  = '0;
        hy_n  = '0;
        hdx_n = '0;
        hdy_n = '0;
        hf_n  = 1'b0;
        if (count_n != '0) begin
            hv_n = 1'b1;
            if (COUNT == CW'(pop_c)) begin
                hx_n  = XC_IN;
                hy_n  = YC_IN;
                hdx_n = dx_c;
                hdy_n = dy_c;
                hf_n  = first_c;
            end else begin
                hx_n  = mem_x[rd_ptr_n];
                hy_n  = mem_y[rd_ptr_n];
                hdx_n = mem_dx[rd_ptr_n];
                hdy_n = mem_dy[rd_ptr_n];
                hf_n  = mem_first[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_ && push_c) begin
            mem_x[wr_ptr]     <= XC_IN;
            mem_y[wr_ptr]     <= YC_IN;
            mem_dx[wr_ptr]    <= dx_c;
            mem_dy[wr_ptr]    <= dy_c;
            mem_first[wr_ptr] <= first_c;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            COUNT     <= '0;
            OVERFLOW  <= 1'b0;
            OUT_VALID <= 1'b0;
            X_OUT     <= '0;
            Y_OUT     <= '0;
            DX        <= '0;
            DY        <= '0;
            FIRST     <= 1'b0;
            prev_x    <= '0;
            prev_y    <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_ptr_n;
            COUNT     <= count_n;
            if (IN_VALID && !push_c) OVERFLOW <= 1'b1;
            OUT_VALID <= hv_n;
            X_OUT     <= hx_n;
            Y_OUT     <= hy_n;
            DX        <= hdx_n;
            DY        <= hdy_n;
            FIRST     <= hf_n;
            // History follows every sample, dropped or not
            if (IN_VALID) begin
                prev_x <= XC_IN;
                prev_y <= YC_IN;
            end
        end
    end

`ifdef GCC_TRACK_BBOX_EN
    // Running bounding box of the current track
    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            XMIN <= '1;
            XMAX <= '0;
            YMIN <= '1;
            YMAX <= '0;
        end else if (IN_VALID) begin
            if (first_c) begin
                XMIN <= XC_IN;
                XMAX <= XC_IN;
                YMIN <= YC_IN;
                YMAX <= YC_IN;
            end else begin
                if (XC_IN < XMIN) XMIN <= XC_IN;
                if (XC_IN > XMAX) XMAX <= XC_IN;
                if (YC_IN < YMIN) YMIN <= YC_IN;
                if (YC_IN > YMAX) YMAX <= YC_IN;
            end
        end else if (CLR) begin
            XMIN <= '1;
            XMAX <= '0;
            YMIN <= '1;
            YMAX <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_gcc_track.sv
// Directed self-checking bench for gcc_track (bbox checks compiled in with GCC_TRACK_BBOX_EN).
module tb_gcc_track;

    logic       CLK = 1'b0;
    logic       RESET_;
    logic       IN_VALID;
    logic [7:0] XC_IN, YC_IN;
    logic       CLR;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] X_OUT, Y_OUT;
    logic [8:0] DX, DY;
    logic       FIRST;
    logic [3:0] COUNT;
    logic       OVERFLOW;
`ifdef GCC_TRACK_BBOX_EN
    logic [7:0] XMIN, XMAX, YMIN, YMAX;
`endif

    int checks = 0;
    int errors = 0;

    gcc_track #(.DW(8), .DEPTH(8), .AW(3)) dut (
        .CLK(CLK), .RESET_(RESET_), .IN_VALID(IN_VALID), .XC_IN(XC_IN), .YC_IN(YC_IN),
        .CLR(CLR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .X_OUT(X_OUT), .Y_OUT(Y_OUT),
        .DX(DX), .DY(DY), .FIRST(FIRST), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
`ifdef GCC_TRACK_BBOX_EN
        , .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y);
        XC_IN    = x;
        YC_IN    = y;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RESET_ = 1'b0;
        step();
        step();
        checks++;
        if ({OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST, COUNT, OVERFLOW} !== 41'd0) begin
            errors++;
            $display("FAIL reset: got v=%b x=%0d y=%0d dx=%h dy=%h f=%b cnt=%0d ovf=%b, want all 0",
                     OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST, COUNT, OVERFLOW);
        end
        RESET_ = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0]  xs[3];
        logic [7:0]  ys[3];
        logic [35:0] exp[3];
        xs[0] = 8'd10; ys[0] = 8'd20; exp[0] = {1'b1, 8'd10, 8'd20, 9'h000, 9'h000, 1'b1};
        xs[1] = 8'd13; ys[1] = 8'd15; exp[1] = {1'b1, 8'd13, 8'd15, 9'h003, 9'h1FB, 1'b0};
        xs[2] = 8'd5;  ys[2] = 8'd15; exp[2] = {1'b1, 8'd5,  8'd15, 9'h1F8, 9'h000, 1'b0};
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            XC_IN = xs[i]; YC_IN = ys[i]; IN_VALID = 1'b1;
            step();
            checks++;
            if ({OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST} !== exp[i]) begin
                errors++;
                $display("FAIL basic[%0d]: got %h, want %h", i,
                         {OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST}, exp[i]);
            end
        end
        IN_VALID = 1'b0;
        step();
        checks++;
        if ({OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST, COUNT} !== 40'd0) begin
            errors++;
            $display("FAIL basic_empty: got v=%b x=%0d cnt=%0d, want all 0", OUT_VALID, X_OUT, COUNT);
        end
    endtask

    task automatic test_extremes();
        logic [7:0]  xs[3];
        logic [35:0] exp[3];
        xs[0] = 8'd0;   exp[0] = {1'b1, 8'd0,   8'd0,   9'h1FB, 9'h1F1, 1'b0};
        xs[1] = 8'd255; exp[1] = {1'b1, 8'd255, 8'd255, 9'h0FF, 9'h0FF, 1'b0};
        xs[2] = 8'd0;   exp[2] = {1'b1, 8'd0,   8'd0,   9'h101, 9'h101, 1'b0};
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            XC_IN = xs[i]; YC_IN = xs[i]; IN_VALID = 1'b1;
            step();
            checks++;
            if ({OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST} !== exp[i]) begin
                errors++;
                $display("FAIL extremes[%0d]: got %h, want %h", i,
                         {OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST}, exp[i]);
            end
        end
        IN_VALID = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [39:0] exp;
        OUT_READY = 1'b0;
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        for (int i = 0; i < 9; i++) begin
            XC_IN = 8'(16 * i + 1); YC_IN = 8'(100 + i); IN_VALID = 1'b1;
            step();
        end
        IN_VALID = 1'b0;
        checks++;
        if ({COUNT, OVERFLOW, OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST} !== {4'd8, 1'b1, 1'b1, 8'd1, 8'd100, 9'd0, 9'd0, 1'b1}) begin
            errors++;
            $display("FAIL full: got cnt=%0d ovf=%b v=%b x=%0d y=%0d f=%b, want cnt=8 ovf=1 v=1 x=1 y=100 f=1",
                     COUNT, OVERFLOW, OUT_VALID, X_OUT, Y_OUT, FIRST);
        end
        step();
        checks++;
        if ({COUNT, X_OUT, Y_OUT, FIRST} !== {4'd8, 8'd1, 8'd100, 1'b1}) begin
            errors++;
            $display("FAIL hold: got cnt=%0d x=%0d y=%0d f=%b, want cnt=8 x=1 y=100 f=1", COUNT, X_OUT, Y_OUT, FIRST);
        end
        // Push and pop at full: delta is against the dropped (129,108) sample
        OUT_READY = 1'b1;
        drive(8'd200, 8'd50);
        checks++;
        if (COUNT !== 4'd8) begin
            errors++;
            $display("FAIL full_pushpop: got cnt=%0d, want 8", COUNT);
        end
        for (int i = 1; i < 8; i++) begin
            exp = {1'b1, 4'(9 - i), 8'(16 * i + 1), 8'(100 + i), 9'h010, 9'h001, 1'b0};
            checks++;
            if ({OUT_VALID, COUNT, X_OUT, Y_OUT, DX, DY, FIRST} !== exp) begin
                errors++;
                $display("FAIL drain[%0d]: got %h, want %h", i, {OUT_VALID, COUNT, X_OUT, Y_OUT, DX, DY, FIRST}, exp);
            end
            step();
        end
        checks++;
        if ({OUT_VALID, COUNT, X_OUT, Y_OUT, DX, DY, FIRST} !== {1'b1, 4'd1, 8'd200, 8'd50, 9'h047, 9'h1C6, 1'b0}) begin
            errors++;
            $display("FAIL after_drop: got x=%0d y=%0d dx=%h dy=%h f=%b cnt=%0d, want x=200 y=50 dx=047 dy=1c6 f=0 cnt=1",
                     X_OUT, Y_OUT, DX, DY, FIRST, COUNT);
        end
        step();
        checks++;
        if ({OUT_VALID, COUNT, X_OUT, Y_OUT, DX, DY, FIRST, OVERFLOW} !== {1'b0, 4'd0, 35'd0, 1'b1}) begin
            errors++;
            $display("FAIL drained: got v=%b cnt=%0d x=%0d dx=%h ovf=%b, want v=0 cnt=0 x=0 dx=0 ovf=1",
                     OUT_VALID, COUNT, X_OUT, DX, OVERFLOW);
        end
    endtask

    task automatic test_clr();
        OUT_READY = 1'b1;
        drive(8'd50, 8'd60);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        drive(8'd40, 8'd40);
        checks++;
        if ({OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST} !== {1'b1, 8'd40, 8'd40, 9'd0, 9'd0, 1'b1}) begin
            errors++;
            $display("FAIL clr_alone: got x=%0d dx=%h dy=%h f=%b, want x=40 dx=0 dy=0 f=1", X_OUT, DX, DY, FIRST);
        end
        CLR = 1'b1;
        drive(8'd45, 8'd30);
        CLR = 1'b0;
        checks++;
        if ({OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST} !== {1'b1, 8'd45, 8'd30, 9'd0, 9'd0, 1'b1}) begin
            errors++;
            $display("FAIL clr_with_sample: got x=%0d dx=%h dy=%h f=%b, want x=45 dx=0 dy=0 f=1", X_OUT, DX, DY, FIRST);
        end
        drive(8'd47, 8'd30);
        checks++;
        if ({OUT_VALID, X_OUT, Y_OUT, DX, DY, FIRST} !== {1'b1, 8'd47, 8'd30, 9'h002, 9'h000, 1'b0}) begin
            errors++;
            $display("FAIL clr_origin: got x=%0d dx=%h dy=%h f=%b, want x=47 dx=002 dy=000 f=0", X_OUT, DX, DY, FIRST);
        end
        step();
    endtask

    task automatic test_reset_mid();
        OUT_READY = 1'b0;
        drive(8'd1, 8'd1);
        drive(8'd2, 8'd2);
        drive(8'd3, 8'd3);
        checks++;
        if (COUNT !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d, want 3", COUNT);
        end
        OUT_READY = 1'b1;
        RESET_ = 1'b0;
        XC_IN = 8'd9; YC_IN = 8'd9; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        checks++;
        if ({OUT_VALID, COUNT, OVERFLOW, X_OUT} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b cnt=%0d ovf=%b x=%0d, want all 0", OUT_VALID, COUNT, OVERFLOW, X_OUT);
        end
        RESET_ = 1'b1;
        drive(8'd7, 8'd9);
        checks++;
        if ({OUT_VALID, COUNT, X_OUT, Y_OUT, DX, DY, FIRST} !== {1'b1, 4'd1, 8'd7, 8'd9, 9'd0, 9'd0, 1'b1}) begin
            errors++;
            $display("FAIL post_reset: got v=%b cnt=%0d x=%0d y=%0d f=%b, want v=1 cnt=1 x=7 y=9 f=1",
                     OUT_VALID, COUNT, X_OUT, Y_OUT, FIRST);
        end
        step();
    endtask

`ifdef GCC_TRACK_BBOX_EN
    task automatic test_bbox();
        RESET_ = 1'b0;
        step();
        RESET_ = 1'b1;
        checks++;
        if ({XMIN, XMAX, YMIN, YMAX} !== 32'hFF00FF00) begin
            errors++;
            $display("FAIL bbox_reset: got %h, want ff00ff00", {XMIN, XMAX, YMIN, YMAX});
        end
        OUT_READY = 1'b1;
        drive(8'd10, 8'd20);
        drive(8'd30, 8'd5);
        drive(8'd20, 8'd40);
        checks++;
        if ({XMIN, XMAX, YMIN, YMAX} !== {8'd10, 8'd30, 8'd5, 8'd40}) begin
            errors++;
            $display("FAIL bbox: got %0d/%0d/%0d/%0d, want 10/30/5/40", XMIN, XMAX, YMIN, YMAX);
        end
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        checks++;
        if ({XMIN, XMAX, YMIN, YMAX} !== 32'hFF00FF00) begin
            errors++;
            $display("FAIL bbox_clr: got %h, want ff00ff00", {XMIN, XMAX, YMIN, YMAX});
        end
    endtask
`endif

    initial begin
        RESET_    = 1'b0;
        IN_VALID  = 1'b0;
        XC_IN     = '0;
        YC_IN     = '0;
        CLR       = 1'b0;
        OUT_READY = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_clr();
        test_reset_mid();
`ifdef GCC_TRACK_BBOX_EN
        test_bbox();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
